// File: rtl/find_first_set_pipe.sv
// Two-stage pipelined find-first-set with per-transaction search direction.
// Stage 1 finds a local winner in each segment; stage 2 picks the winning segment.
module find_first_set_pipe #(
  parameter  int WIDTH     = 32,
  parameter  int SEG_WIDTH = 8,
  localparam int LOC_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] vector,
  input  logic             msb_first,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             found,
  output logic [LOC_W-1:0] location,
  output logic [WIDTH-1:0] remaining
);

  localparam int NSEG      = WIDTH / SEG_WIDTH;
  localparam int SEG_LOC_W = $clog2(SEG_WIDTH);

  logic                 s2_adv;
  logic                 s1_adv;

  logic [NSEG-1:0]      seg_any;
  logic [SEG_LOC_W-1:0] seg_idx [NSEG];

  logic                 s1_vld;
  logic [NSEG-1:0]      s1_any;
  logic [SEG_LOC_W-1:0] s1_idx [NSEG];
  logic [WIDTH-1:0]     s1_vector;
  logic                 s1_msb;

  logic                 win_found;
  logic [LOC_W-1:0]     win_loc;
  logic [WIDTH-1:0]     win_remaining;

  // in_rdy is combinational from out_rdy; there is no skid buffer.
  assign s2_adv = !out_vld || out_rdy;
  assign s1_adv = !s1_vld || s2_adv;
  assign in_rdy = s1_adv;

  // Later matches overwrite earlier ones, so the scan order picks the winner.
  always_comb begin
    for (int s = 0; s < NSEG; s++) begin
      seg_any[s] = |vector[s*SEG_WIDTH +: SEG_WIDTH];
      seg_idx[s] = '0;
      for (int i = 0; i < SEG_WIDTH; i++) begin
        if (msb_first) begin
          if (vector[s*SEG_WIDTH + i])
            seg_idx[s] = SEG_LOC_W'(i);
        end else begin
          if (vector[s*SEG_WIDTH + SEG_WIDTH - 1 - i])
            seg_idx[s] = SEG_LOC_W'(SEG_WIDTH - 1 - i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
    end else if (s1_adv) begin
      s1_vld <= in_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_vld) begin
      s1_any    <= seg_any;
      s1_idx    <= seg_idx;
      s1_vector <= vector;
      s1_msb    <= msb_first;
    end
  end

  always_comb begin
    win_found = |s1_any;
    win_loc   = '0;
    if (s1_msb) begin
      for (int s = 0; s < NSEG; s++)
        if (s1_any[s])
          win_loc = LOC_W'(s * SEG_WIDTH) + LOC_W'(s1_idx[s]);
    end else begin
      for (int s = NSEG - 1; s >= 0; s--)
        if (s1_any[s])
          win_loc = LOC_W'(s * SEG_WIDTH) + LOC_W'(s1_idx[s]);
    end
    win_remaining = s1_vector & ~(WIDTH'(win_found) << win_loc);
  end

  // Result data loads only for real transactions so bubbles never disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld   <= 1'b0;
      found     <= 1'b0;
      location  <= '0;
      remaining <= '0;
    end else if (s2_adv) begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        found     <= win_found;
        location  <= win_loc;
        remaining <= win_remaining;
      end
    end
  end

endmodule
